// File: rtl/bufg_enable_sequencer_if.sv
// -----------------------------------------------------------------------------
// bufg_enable_sequencer_if
//
// Purpose: groups the request/status signals of the staggered clock-domain
// enable sequencer into one bundle.
//
// Signals:
//   start  - level, requests power-up of all domains
//   stop   - level, requests power-down of all domains
//   en     - N-bit per-domain enable, thermometer coded
//   busy   - sequencer is ramping (up or down)
//   ready  - all N domains are enabled
//
// Modports:
//   master - the controller that issues start/stop and watches status
//   slave  - the sequencer itself
// -----------------------------------------------------------------------------
interface bufg_enable_sequencer_if #(
    parameter int N = 8
) ();

    logic         start;
    logic         stop;
    logic [N-1:0] en;
    logic         busy;
    logic         ready;

    modport master (
        output start,
        output stop,
        input  en,
        input  busy,
        input  ready
    );

    modport slave (
        input  start,
        input  stop,
        output en,
        output busy,
        output ready
    );

endinterface

// File: rtl/bufg_enable_sequencer.sv
// -----------------------------------------------------------------------------
// bufg_enable_sequencer
//
// Purpose: switches on up to N clock domains (each behind its own global clock
// buffer) one at a time, spaced G = 2^GAP_BITS cycles apart, so the clock
// network and supply never see all domains start at once. Power-down is
// either staggered in reverse order or instantaneous, chosen at build time.
//
// Build option:
//   BUFG_SEQ_REVERSE_OFF_EN - when defined, stop ramps the enables down one
//                             per gap, highest index first (RAMP_DOWN state
//                             exists). When undefined, stop clears every
//                             enable on one edge and returns to OFF.
//
// Parameters:
//   N        - number of sequenced domains, 2..8
//   GAP_BITS - gap between steps is 2^GAP_BITS cycles, 1..21
//
// Ports:
//   clk        - board clock, all registers on its rising edge
//   rst        - asynchronous, active-low reset
//   bus.start  - in,  power-up request (level)
//   bus.stop   - in,  power-down request (level), wins over start
//   bus.en     - out, per-domain enables, registered
//   bus.busy   - out, ramp in progress, registered
//   bus.ready  - out, all domains enabled, registered
//
// State table:
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   OFF       | all enables low, waiting for start
//   RAMP_UP   | enabling one more domain every G cycles
//   ON        | all N domains enabled, waiting for stop
//   RAMP_DOWN | disabling one domain every G cycles, highest first
//             | (only present with BUFG_SEQ_REVERSE_OFF_EN)
// -----------------------------------------------------------------------------
module bufg_enable_sequencer #(
    parameter int N        = 8,
    parameter int GAP_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bufg_enable_sequencer_if.slave  bus
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("bufg_enable_sequencer: N must be in 2..8");
    end
    if (GAP_BITS < 1 || GAP_BITS > 21) begin : g_bad_gap
        $error("bufg_enable_sequencer: GAP_BITS must be in 1..21");
    end

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2
`ifdef BUFG_SEQ_REVERSE_OFF_EN
        ,
        RAMP_DOWN = 2'd3
`endif
    } state_t;

    state_t              state;
    logic [GAP_BITS-1:0] gap_cnt;
    logic [IDX_W-1:0]    idx;
    logic [N-1:0]        en_q;
    logic                busy_q;
    logic                ready_q;

    // The gap counter runs 0..G-1; the cycle it sits at G-1 is the step edge.
    logic gap_wrap;
    assign gap_wrap = &gap_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= OFF;
            gap_cnt <= '0;
            idx     <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    // stop has priority, and in OFF it means "do nothing".
                    if (bus.start && !bus.stop) begin
                        state   <= RAMP_UP;
                        en_q    <= N'(1);
                        idx     <= IDX_ONE;
                        gap_cnt <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end

                RAMP_UP: begin
                    if (bus.stop) begin
`ifdef BUFG_SEQ_REVERSE_OFF_EN
                        // Highest set bit is idx-1. If that is bit 0 the ramp
                        // down is complete on this very edge.
                        gap_cnt <= '0;
                        if (idx == IDX_ONE) begin
                            state  <= OFF;
                            en_q   <= '0;
                            idx    <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            state           <= RAMP_DOWN;
                            en_q[idx - 1'b1] <= 1'b0;
                            idx             <= idx - IDX_W'(2);
                        end
`else
                        state   <= OFF;
                        en_q    <= '0;
                        idx     <= '0;
                        gap_cnt <= '0;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                        if (gap_wrap) begin
                            en_q[idx] <= 1'b1;
                            if (idx == IDX_LAST) begin
                                state   <= ON;
                                idx     <= '0;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                end

                ON: begin
                    if (bus.stop) begin
                        ready_q <= 1'b0;
                        gap_cnt <= '0;
`ifdef BUFG_SEQ_REVERSE_OFF_EN
                        state       <= RAMP_DOWN;
                        en_q[N-1]   <= 1'b0;
                        idx         <= IDX_W'(N - 2);
                        busy_q      <= 1'b1;
`else
                        state  <= OFF;
                        en_q   <= '0;
                        idx    <= '0;
                        busy_q <= 1'b0;
`endif
                    end
                end

`ifdef BUFG_SEQ_REVERSE_OFF_EN
                RAMP_DOWN: begin
                    // start and stop are deliberately not looked at here.
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_wrap) begin
                        en_q[idx] <= 1'b0;
                        if (idx == '0) begin
                            state  <= OFF;
                            busy_q <= 1'b0;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state   <= OFF;
                    gap_cnt <= '0;
                    idx     <= '0;
                    en_q    <= '0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en    = en_q;
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_bufg_enable_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bufg_enable_sequencer
//
// Purpose: directed check of the enable sequencer with N=8, GAP_BITS=2 (G=4).
// Expected values follow the build option BUFG_SEQ_REVERSE_OFF_EN.
// -----------------------------------------------------------------------------
module tb_bufg_enable_sequencer;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] en_plus1;

    bufg_enable_sequencer_if #(.N(8)) bus ();

    bufg_enable_sequencer #(
        .N        (8),
        .GAP_BITS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] therm(input int k);
        therm = 8'((1 << k) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Continuous invariants: thermometer-coded enables, busy/ready exclusive.
    always @(negedge clk) begin
        en_plus1 = bus.en + 8'd1;
        total++;
        assert ((en_plus1 & bus.en) === 8'h00) else begin
            bad++;
            $error("FAIL thermometer: observed=%h expected=thermometer", bus.en);
        end
        total++;
        assert (!(bus.busy && bus.ready)) else begin
            bad++;
            $error("FAIL busy_ready_excl: observed=%b%b expected=not both", bus.busy, bus.ready);
        end
    end

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        step(3);
        chk8("reset_en", bus.en, 8'h00);
        chk1("reset_busy", bus.busy, 1'b0);
        chk1("reset_ready", bus.ready, 1'b0);
        rst = 1'b1;
        step(2);
        chk8("idle_en", bus.en, 8'h00);

        // Scenario 1: staggered power-up
        bus.start = 1'b1;
        tick();
        chk8("up_first_en", bus.en, 8'h01);
        chk1("up_first_busy", bus.busy, 1'b1);
        chk1("up_first_ready", bus.ready, 1'b0);
        bus.start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step(3);
            chk8("up_hold_en", bus.en, therm(i));
            if (i == 7) begin
                chk1("up_last_busy", bus.busy, 1'b1);
                chk1("up_last_ready", bus.ready, 1'b0);
            end
            step(1);
            chk8("up_step_en", bus.en, therm(i + 1));
        end
        chk1("on_ready", bus.ready, 1'b1);
        chk1("on_busy", bus.busy, 1'b0);
        step(5);
        chk8("on_hold_en", bus.en, 8'hFF);

        // Scenario 2/3: power-down from ON
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk1("down_ready", bus.ready, 1'b0);
`ifdef BUFG_SEQ_REVERSE_OFF_EN
        chk8("down_first_en", bus.en, 8'h7F);
        chk1("down_first_busy", bus.busy, 1'b1);
        for (int j = 1; j < 8; j++) begin
            step(3);
            chk8("down_hold_en", bus.en, therm(8 - j));
            if (j == 7) chk1("down_last_busy", bus.busy, 1'b1);
            step(1);
            chk8("down_step_en", bus.en, therm(7 - j));
        end
        chk1("down_done_busy", bus.busy, 1'b0);
`else
        chk8("down_all_en", bus.en, 8'h00);
        chk1("down_all_busy", bus.busy, 1'b0);
        step(1);
        chk1("down_busy_stays_low", bus.busy, 1'b0);
`endif
        step(3);

        // Scenario 4: stop aborts ramp-up while start is held
        bus.start = 1'b1;
        tick();
        chk8("abort_first_en", bus.en, 8'h01);
        step(8);
        chk8("abort_pre_en", bus.en, 8'h07);
        step(1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
`ifdef BUFG_SEQ_REVERSE_OFF_EN
        chk8("abort_s_en", bus.en, 8'h03);
        chk1("abort_s_busy", bus.busy, 1'b1);
        step(4);
        chk8("abort_s4_en", bus.en, 8'h01);
        step(4);
        chk8("abort_s8_en", bus.en, 8'h00);
        chk1("abort_s8_busy", bus.busy, 1'b0);
`else
        chk8("abort_s_en", bus.en, 8'h00);
        chk1("abort_s_busy", bus.busy, 1'b0);
`endif
        // start still high: restarts on the first edge seen in OFF
        tick();
        chk8("restart_en", bus.en, 8'h01);
        chk1("restart_busy", bus.busy, 1'b1);
        // stop with only bit 0 set returns to OFF on the same edge
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk8("abort_h0_en", bus.en, 8'h00);
        chk1("abort_h0_busy", bus.busy, 1'b0);
        step(2);

        // Scenario 5: start and stop together
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step(2);
        chk8("both_off_en", bus.en, 8'h00);
        chk1("both_off_busy", bus.busy, 1'b0);
        bus.stop = 1'b0;
        tick();
        bus.start = 1'b0;
        step(28);
        chk1("both_on_ready", bus.ready, 1'b1);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk1("both_on_ready_drop", bus.ready, 1'b0);
`ifdef BUFG_SEQ_REVERSE_OFF_EN
        chk8("both_on_en", bus.en, 8'h7F);
        chk1("both_on_busy", bus.busy, 1'b1);
        step(28);
        chk8("both_on_done_en", bus.en, 8'h00);
`else
        chk8("both_on_en", bus.en, 8'h00);
        chk1("both_on_busy", bus.busy, 1'b0);
`endif
        step(2);

        // Scenario 6: asynchronous reset mid-ramp
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        step(16);
        chk8("mid_en", bus.en, 8'h1F);
        #2;
        rst = 1'b0;
        #1;
        chk8("async_rst_en", bus.en, 8'h00);
        chk1("async_rst_busy", bus.busy, 1'b0);
        chk1("async_rst_ready", bus.ready, 1'b0);
        step(2);
        rst = 1'b1;
        step(1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk8("post_rst_en", bus.en, 8'h01);
        step(4);
        chk8("post_rst_step_en", bus.en, 8'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bufg_enable_sequencer.md
# bufg_enable_sequencer

Staggered enable sequencer for up to N counter domains, each fed by its own global clock buffer from one board clock. Domains are switched on one at a time with a fixed gap, so simultaneous start-up load on the clock network and supply is avoided. Domains are switched off in reverse order, or all at once, depending on build configuration. The block runs on the same board clock that feeds the buffers and drives per-domain enables into the downstream counter/logic blocks.

## Interface
Parameters:
- `N`, default 8: number of sequenced domains; legal range 2..8.
- `GAP_BITS`, default 4: step gap G = 2^GAP_BITS clock cycles; legal range 1..21.

Ports:
- `clk`, input, 1: board clock; every register is on its rising edge.
- `rst`, input, 1: reset, asynchronous assert, active-low. On release, the block starts in OFF.
- `start`, input, 1: level; requests power-up, sampled each edge.
- `stop`, input, 1: level; requests power-down, sampled each edge.
- `en`, output, N: per-domain enable; `en[i]` high means domain i runs.
- `busy`, output, 1: high while ramping, either up or down.
- `ready`, output, 1: high only when all N enables are on (state ON).

## Operation
- State machine has four states: OFF, RAMP_UP, ON, RAMP_DOWN. All outputs are registered.
- Reset values: state = OFF, `en` = 0, `busy` = 0, `ready` = 0, gap counter = 0, index = 0.
- Internal registers:
  - Gap counter: GAP_BITS wide, counts 0..G-1, wraps to 0 on the step edge.
  - Index: $clog2(N) bits wide, points at the next bit to set or clear.
- OFF:
  - `stop` is ignored.
  - `start`=1 moves to RAMP_UP on that edge. At the same edge `en[0]`=1, index = 1, gap counter = 0, `busy` = 1.
- RAMP_UP:
  - Gap counter increments each cycle.
  - When it wraps, set `en[index]` and increment index.
  - When `en[N-1]` is set, move to ON on the same edge: `busy` = 0, `ready` = 1.
  - `start` is ignored in this state.
- ON:
  - `start` is ignored.
  - `stop`=1 enters power-down (see Configuration). `ready` drops on that edge.
- RAMP_DOWN:
  - On entry, the highest set enable bit is cleared on the entry edge and the gap counter is reset.
  - Each gap-counter wrap clears the next lower bit.
  - Clearing `en[0]` moves to OFF on the same edge with `busy` = 0.
  - `start` and `stop` are ignored until OFF is reached.
- `stop` during RAMP_UP aborts the ramp. Power-down begins from the currently highest set bit.
- If `stop` and `start` are both high on the same edge, `stop` wins in every state. In OFF both are ignored, so the block stays OFF.
- `en` is always thermometer-coded: bits 0..k set, all others clear. No other pattern is legal; the bench asserts this.
- Reset mid-ramp clears every output immediately, without waiting for a clock edge.

## Timing
- Let E be the edge at which `start` is sampled high in OFF.
- `en[i]` rises at edge E + i·G. `ready` rises at E + (N-1)·G.
- Let S be the edge at which `stop` is sampled high, with highest set bit h (macro defined). `en[h-j]` falls at S + j·G. OFF is reached at S + h·G.
- Without the macro, all `en` bits fall at S, and OFF is reached at S.
- `busy` and `ready` are never high together.
- There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `BUFG_SEQ_REVERSE_OFF_EN`.
- Defined: `stop` enters RAMP_DOWN and clears enables one per G cycles, highest index first. `busy` stays high throughout power-down.
- Undefined: the RAMP_DOWN state is not compiled. `stop` clears all of `en` in one cycle and moves straight to OFF, with `busy` = 0 and `ready` = 0 on that edge.

## Test plan
All scenarios use N=8, GAP_BITS=2 (G=4).
1. Reset, then `start` pulse at edge 10:
   - `en` = 0x01 at edge 10, 0x03 at 14, … 0xFF at 38.
   - `ready` rises at 38; `busy` is high for edges 10..37.
2. From ON, `stop` at edge 50 (macro defined):
   - `en` = 0x7F at 50, 0x3F at 54, … 0x00 at 78.
   - OFF at 78; `busy` is high for edges 50..77.
3. Same as scenario 2 with the macro undefined:
   - `en` = 0x00 and `ready` = 0 at edge 50; `busy` never rises.
4. `start` at edge 10, `stop` at edge 20, when `en` = 0x07 (macro defined):
   - `en` = 0x03 at 20, 0x01 at 24, 0x00 at 28.
   - `start` held high throughout has no effect until OFF.
5. Simultaneous events:
   - `start` and `stop` both high in OFF: `en` stays 0.
   - Both high in ON: power-down begins.
6. Reset mid-ramp:
   - Drive `rst` low asynchronously mid-ramp while `en` = 0x1F. `en`, `busy` and `ready` go to 0 before the next edge.
   - Release `rst`, then `start`: the sequence restarts from 0x01.
